gcd_operand_feeder: RTL and testbench

- Upstream stage of the GCD core (datapath plus controller).
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each pair into the core's single 16-bit data_in bus: A during the start cycle, then B on the next cycle. Waits for done, then pulses core_rst to return the core controller to S0 for the next pair.
- Screens out zero operands, which would otherwise make the subtract loop spin forever.

---
 rtl/gcd_operand_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_gcd_operand_feeder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder
// -----------------------------------------------------------------------------
// Upstream stage of the GCD core. Operand pairs arrive over a valid/ready
// handshake and are buffered in a small FIFO. Each pair is then sequenced onto
// the core's single data_in bus: A during the start cycle, B on the next cycle.
// The feeder waits for core_done and then pulses core_rst so the core
// controller is back in S0 for the next pair. Pairs with a zero operand are
// dropped, because they would make the core's subtract loop spin forever.
//
// Ports:
//   clk, rst          single rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand pair handshake (push when both are high)
//   in_a, in_b        operand pair, captured at the push edge
//   data_out          drives core data_in
//   start             drives core start (high for the A cycle only)
//   core_rst          one-cycle restart of the core controller after done
//   core_done         done flag from the core
//   busy              a pair is in flight (state is not IDLE)
//   zero_err          one-cycle pulse when a pair is dropped for a zero operand
//   count             FIFO occupancy in pairs
//   timeout_err       (only with GCD_FEEDER_TIMEOUT_EN) one-cycle pulse when
//                     the core failed to finish within TIMEOUT cycles
//
// Optional feature macro: GCD_FEEDER_TIMEOUT_EN adds a wait counter that aborts
// a hung computation after TIMEOUT cycles in WAIT.
// -----------------------------------------------------------------------------
module gcd_operand_feeder #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       data_out,
    output logic                   start,
    output logic                   core_rst,
    input  logic                   core_done,
    output logic                   busy,
    output logic                   zero_err,
    output logic [$clog2(DEPTH):0] count
`ifdef GCD_FEEDER_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Catch illegal configurations at elaboration rather than in silicon.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("gcd_operand_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];
    logic [WIDTH-1:0]  head_a, head_b;
    logic              push, pop;
    logic              head_zero;

`ifdef GCD_FEEDER_TIMEOUT_EN
    logic [16:0]       wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    assign head_a    = mem_a[rd_ptr_q];
    assign head_b    = mem_b[rd_ptr_q];
    assign head_zero = (head_a == '0) || (head_b == '0);
    assign in_ready  = (count_q != FULL);
    assign push      = in_valid && in_ready;
    assign count     = count_q;
    assign busy      = (state_q != IDLE);

    // Pair storage carries no reset: occupancy and pointers alone decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a;
            mem_b[wr_ptr_q] <= in_b;
        end
    end

    // FIFO bookkeeping. DEPTH is a power of two, so the pointers wrap on
    // natural overflow. A simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer. Core-facing outputs decode only registered state and the
    // FIFO head, so there is no combinational path from in_* to the core.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        data_out = '0;
        start    = 1'b0;
        core_rst = 1'b0;
        zero_err = 1'b0;
`ifdef GCD_FEEDER_TIMEOUT_EN
        timeout_err_d = 1'b0;
        wait_cnt_d    = (state_q == WAIT) ? wait_cnt_q + 17'd1 : 17'd0;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    // The core in S0 reloads A every cycle, so presenting
                    // head A early is harmless.
                    data_out = head_a;
                    if (head_zero) begin
                        pop      = 1'b1;
                        zero_err = 1'b1;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                start    = 1'b1;
                data_out = head_a;
                state_d  = LOAD_B;
            end
            LOAD_B: begin
                // The core has captured B at this edge, so the slot is free.
                data_out = head_b;
                pop      = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_d = RECOVER;
                end
`ifdef GCD_FEEDER_TIMEOUT_EN
                else if (wait_cnt_q == 17'(TIMEOUT - 1)) begin
                    state_d       = RECOVER;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            RECOVER: begin
                core_rst = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and FIFO registers. Reset drops everything in flight; the core is
    // reset by the same system reset, so no core_rst is needed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef GCD_FEEDER_TIMEOUT_EN
    // The timeout flag is registered so it lines up with the core_rst cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Testbench for gcd_operand_feeder: directed pairs, a behavioural core model,
// and a scoreboard that checks every issued or dropped pair against push order.
module tb_gcd_operand_feeder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 65535;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [WIDTH-1:0] data_out;
    logic             start;
    logic             core_rst;
    logic             core_done;
    logic             busy;
    logic             zero_err;
    logic [2:0]       count;
`ifdef GCD_FEEDER_TIMEOUT_EN
    logic             timeout_err;
`endif

    gcd_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .data_out  (data_out),
        .start     (start),
        .core_rst  (core_rst),
        .core_done (core_done),
        .busy      (busy),
        .zero_err  (zero_err),
        .count     (count)
`ifdef GCD_FEEDER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               zero;
    } pair_t;

    pair_t exp_q[$];
    int    check_count = 0;
    int    pass_count  = 0;
    int    zero_seen   = 0;

    // Core model knobs
    int    done_delay = 10;
    bit    stall      = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offer one pair and hold it until accepted; expectation is queued on accept.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int    waited = 0;
        pair_t p;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("push_accepted", in_ready, 1);
        @(posedge clk);
        p.a    = a;
        p.b    = b;
        p.zero = (a == '0) || (b == '0);
        exp_q.push_back(p);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        @(negedge clk);
        while (!start && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, start, 1);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        @(negedge clk);
        while ((count != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_count"}, count, 0);
        checkOutput({name, "_busy"}, busy, 0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_count"}, count, 0);
        checkOutput({name, "_in_ready"}, in_ready, 1);
        checkOutput({name, "_start"}, start, 0);
        checkOutput({name, "_data_out"}, data_out, 0);
        checkOutput({name, "_core_rst"}, core_rst, 0);
        checkOutput({name, "_zero_err"}, zero_err, 0);
    endtask

    // Behavioural core: captures the start, raises done a fixed number of
    // cycles later (unless stalled) and drops it on core_rst or reset.
    initial begin
        int  cnt     = 0;
        bit  pending = 1'b0;
        core_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                core_done = 1'b0;
                pending   = 1'b0;
                cnt       = 0;
            end else if (start) begin
                pending   = 1'b1;
                cnt       = done_delay + 1;
                core_done = 1'b0;
            end else if (core_rst) begin
                core_done = 1'b0;
                pending   = 1'b0;
            end else if (pending) begin
                if (cnt > 0) cnt--;
                if (cnt == 0 && !stall) begin
                    core_done = 1'b1;
                    pending   = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every start or zero_err consumes the oldest pair.
    initial begin
        bit               check_b = 1'b0;
        logic [WIDTH-1:0] pend_b  = '0;
        pair_t            p;
        forever begin
            @(negedge clk);
            if (rst) begin
                check_b = 1'b0;
                continue;
            end
            if (check_b) begin
                checkOutput("data_out_B", data_out, pend_b);
                checkOutput("start_low_B", start, 0);
                checkOutput("busy_B", busy, 1);
                check_b = 1'b0;
            end
            if (zero_err) begin
                zero_seen++;
                checkOutput("zero_err_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    checkOutput("zero_drop_pair", p.zero, 1);
                end
            end
            if (start) begin
                checkOutput("start_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    checkOutput("start_pair_nonzero", p.zero, 0);
                    checkOutput("data_out_A", data_out, p.a);
                    pend_b  = p.b;
                    check_b = 1'b1;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("%0d/%0d checks passed", pass_count, check_count + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int zero_before;
        logic [WIDTH-1:0] vec_a [6] = '{16'd30, 16'd17, 16'd44, 16'd13, 16'd56, 16'd27};
        logic [WIDTH-1:0] vec_b [6] = '{16'd12, 16'd51, 16'd33, 16'd39, 16'd8,  16'd18};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        #3;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: single pair, core done after 10 cycles
        $display("[TB] test 1: single pair 48/18");
        done_delay = 10;
        applyStimulus(16'd48, 16'd18);
        begin
            int n = 0;
            @(negedge clk);
            while (!core_done && n < 200) begin
                @(negedge clk);
                n++;
            end
            checkOutput("t1_done_seen", core_done, 1);
            checkOutput("t1_busy_in_wait", busy, 1);
            checkOutput("t1_core_rst_before", core_rst, 0);
        end
        @(negedge clk);
        checkOutput("t1_core_rst_pulse", core_rst, 1);
        @(negedge clk);
        checkOutput("t1_core_rst_end", core_rst, 0);
        checkOutput("t1_busy_end", busy, 0);
        checkOutput("t1_count_end", count, 0);

        // 2: fill the FIFO while the core is stalled
        $display("[TB] test 2: fill FIFO with core stalled");
        stall = 1'b1;
        applyStimulus(16'd100, 16'd75);
        repeat (4) @(negedge clk);
        applyStimulus(16'd12, 16'd8);
        applyStimulus(16'd9, 16'd6);
        applyStimulus(16'd35, 16'd14);
        applyStimulus(16'd81, 16'd27);
        @(negedge clk);
        checkOutput("t2_count_full", count, 4);
        checkOutput("t2_in_ready_full", in_ready, 0);
        in_valid = 1'b1;
        in_a     = 16'd64;
        in_b     = 16'd48;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t2_fifth_blocked", in_ready, 0);
            checkOutput("t2_count_held", count, 4);
        end
        stall = 1'b0;
        applyStimulus(16'd64, 16'd48);
        @(negedge clk);
        checkOutput("t2_count_after_fifth", count, 4);
        waitIdle("t2_drain");

        // 3: zero operand dropped, following pair issued
        $display("[TB] test 3: zero operand screening");
        done_delay  = 5;
        zero_before = zero_seen;
        applyStimulus(16'd0, 16'd7);
        applyStimulus(16'd21, 16'd14);
        waitIdle("t3_drain");
        checkOutput("t3_zero_err_pulses", zero_seen - zero_before, 1);

        // 4: push and pop on the same edge at count DEPTH-1, across wrap
        $display("[TB] test 4: simultaneous push/pop at count 3");
        stall = 1'b1;
        applyStimulus(16'd1000, 16'd10);
        repeat (3) @(negedge clk);
        applyStimulus(16'd91, 16'd13);
        applyStimulus(16'd26, 16'd65);
        applyStimulus(16'd77, 16'd22);
        @(negedge clk);
        checkOutput("t4_count_setup", count, 3);
        done_delay = 3;
        stall      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pair_t p;
            waitStart("t4_start");
            @(negedge clk);
            checkOutput("t4_count_at_loadb", count, 3);
            checkOutput("t4_ready_at_loadb", in_ready, 1);
            in_valid = 1'b1;
            in_a     = vec_a[i];
            in_b     = vec_b[i];
            @(posedge clk);
            p.a    = vec_a[i];
            p.b    = vec_b[i];
            p.zero = 1'b0;
            exp_q.push_back(p);
            #1 in_valid = 1'b0;
            @(negedge clk);
            checkOutput("t4_count_after_pushpop", count, 3);
        end
        waitIdle("t4_drain");

        // 5: asynchronous reset during WAIT with two pairs queued
        $display("[TB] test 5: reset during WAIT");
        stall = 1'b1;
        applyStimulus(16'd50, 16'd20);
        applyStimulus(16'd8, 16'd4);
        applyStimulus(16'd9, 16'd3);
        repeat (3) @(negedge clk);
        checkOutput("t5_busy_before", busy, 1);
        checkOutput("t5_count_before", count, 2);
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("t5_async");
        exp_q.delete();
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("t5_no_core_rst", core_rst, 0);
            checkOutput("t5_idle", busy, 0);
        end

`ifdef GCD_FEEDER_TIMEOUT_EN
        // 6: core never finishes; abort after TIMEOUT cycles in WAIT
        $display("[TB] test 6: wait timeout");
        stall = 1'b1;
        applyStimulus(16'd40, 16'd16);
        waitStart("t6_start");
        begin
            pair_t p;
            in_valid = 1'b1;
            in_a     = 16'd27;
            in_b     = 16'd9;
            @(posedge clk);
            p.a    = 16'd27;
            p.b    = 16'd9;
            p.zero = 1'b0;
            exp_q.push_back(p);
            #1 in_valid = 1'b0;
        end
        repeat (20) @(negedge clk);
        checkOutput("t6_timeout_early", timeout_err, 0);
        checkOutput("t6_core_rst_early", core_rst, 0);
        @(negedge clk);
        checkOutput("t6_timeout_pulse", timeout_err, 1);
        checkOutput("t6_core_rst_pulse", core_rst, 1);
        stall      = 1'b0;
        done_delay = 5;
        @(negedge clk);
        checkOutput("t6_timeout_end", timeout_err, 0);
        waitIdle("t6_drain");
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
